tile_read_assembler: RTL and testbench
======================================

TILE_READ_ASSEMBLER -- requirements
Module: tile_read_assembler

Interface
REQ-001 Parameter DATA_WIDTH, default 256: width of one BRAM read word.
REQ-002 Parameter NUM_FETCHES_PER_TILE, default 2: BRAM words per tile; must be >= 1.
REQ-003 Parameter BRAM_LATENCY, default 1: cycles from bram_en to valid bram_rdata; must be >= 1.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 bram_en  input  1  read-issue strobe from the upstream fetch stage; one word requested per high cycle.
REQ-007 bram_rdata  input  DATA_WIDTH  BRAM read data, valid BRAM_LATENCY cycles after each bram_en.
REQ-008 flush  input  1  synchronous clear of all buffered data and status.
REQ-009 tile_ready  input  1  downstream consumer accepts tile this cycle.
REQ-010 tile_valid  output  1  tile_data holds a complete tile.
REQ-011 tile_data  output  DATA_WIDTH*NUM_FETCHES_PER_TILE  assembled tile.
REQ-012 fetch_ok  output  1  upstream may issue the next tile fetch.
REQ-013 overflow  output  1  sticky: a read word arrived with no space and was dropped.
REQ-014 tiles_delivered  output  16  count of tiles accepted downstream.

Function
REQ-015 A BRAM_LATENCY-deep shift register of bram_en SHALL form rd_valid; rd_valid high marks bram_rdata as a captured beat.
REQ-016 A beat counter SHALL place beat k (k = 0 first) in bits [k*DATA_WIDTH +: DATA_WIDTH] of the assembly buffer.
REQ-017 Assembly states: COLLECT (accepting beats) and HOLD (complete tile waiting for the output slot).
REQ-018 On the last beat (counter == NUM_FETCHES_PER_TILE-1): if the output slot is empty or is handshaking this cycle, the tile, including the current beat, SHALL load into the output register and the counter SHALL return to 0 in COLLECT; otherwise the assembly SHALL enter HOLD.
REQ-019 In HOLD, the held tile SHALL move to the output register on the edge after tile_valid && tile_ready, and the assembly SHALL return to COLLECT.
REQ-020 tile_valid SHALL rise on the edge after the final beat when the output slot is free, giving BRAM_LATENCY+1 cycles from the last bram_en.
REQ-021 tile_valid SHALL stay high and tile_data stable until tile_valid && tile_ready; the handshake clears tile_valid unless a new tile loads on the same edge.
REQ-022 Simultaneous handshake and tile completion SHALL produce back-to-back tile_valid with no bubble.
REQ-023 fetch_ok SHALL be high only in COLLECT with beat counter == 0 and no rd_valid in flight, and low otherwise.
REQ-024 A beat arriving in HOLD SHALL be dropped, set overflow, and leave the counter, held tile and output unchanged.
REQ-025 overflow SHALL clear only on reset or flush.
REQ-026 tiles_delivered SHALL increment by 1 per handshake and wrap from 0xFFFF to 0.
REQ-027 flush SHALL override all other inputs: clear the delay line, counter, HOLD, tile_valid and overflow. tiles_delivered is unaffected.
REQ-028 With NUM_FETCHES_PER_TILE == 1, every beat is a last beat.

Reset
REQ-029 On rst_n low: tile_valid=0, tile_data=0, fetch_ok=1, overflow=0, tiles_delivered=0, delay line cleared, state COLLECT, counter 0.
REQ-030 Deassertion mid-transfer SHALL discard any partial tile. Beats whose bram_en preceded reset SHALL NOT be captured.

Verification
REQ-031 Basic tile (defaults): bram_en high 2 cycles with rdata A then B, tile_ready=1 -> tile_valid for 1 cycle, 2 cycles after the last bram_en; tile_data={B,A}; tiles_delivered=1.
REQ-032 Backpressure: tile_ready=0 and two full tiles fetched -> first tile held on output, second in HOLD, fetch_ok=0; a third beat sets overflow=1. Raising tile_ready delivers tiles 1 then 2 on consecutive cycles.
REQ-033 Back-to-back handshake: last beat of tile 2 coincides with the handshake of tile 1 -> tile_valid stays high with no gap and tile_data switches to tile 2.
REQ-034 Flush: flush pulsed after 1 of 2 beats -> next two beats C, D form tile {D,C}; overflow=0.
REQ-035 Wrap: preload 0xFFFF handshakes, then one more -> tiles_delivered=0.
REQ-036 Reset mid-tile: rst_n low between beat 0 and beat 1 -> all outputs at reset values; the stale beat 1 is not captured.

Source files
------------

// File: rtl/tile_read_assembler.sv
// Collects NUM_FETCHES_PER_TILE BRAM read beats into one tile and presents it
// to a downstream consumer through a single valid/ready output register.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_COLLECT | accepting read beats into the assembly buffer
// S_HOLD    | assembly buffer holds a complete tile; output slot still busy
module tile_read_assembler #(
   parameter int DATA_WIDTH           = 256,
   parameter int NUM_FETCHES_PER_TILE = 2,
   parameter int BRAM_LATENCY         = 1
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     bram_en_i,
   input  logic [DATA_WIDTH-1:0]                    bram_rdata_i,
   input  logic                                     flush_i,
   input  logic                                     tile_ready_i,
   output logic                                     tile_valid_o,
   output logic [DATA_WIDTH*NUM_FETCHES_PER_TILE-1:0] tile_data_o,
   output logic                                     fetch_ok_o,
   output logic                                     overflow_o,
   output logic [15:0]                              tiles_delivered_o
);

   localparam int TW = DATA_WIDTH * NUM_FETCHES_PER_TILE;
   localparam int CW = (NUM_FETCHES_PER_TILE > 1) ? $clog2(NUM_FETCHES_PER_TILE) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_FETCHES_PER_TILE - 1);

   typedef enum logic {
      S_COLLECT,
      S_HOLD
   } state_t;

   state_t                  state_q;
   logic [BRAM_LATENCY-1:0] en_sr_q, en_sr_d;
   logic [CW-1:0]           cnt_q;
   logic [TW-1:0]           asm_q, asm_d;
   logic [TW-1:0]           out_q;
   logic                    valid_q;
   logic                    overflow_q;
   logic [15:0]             count_q;
   logic                    rd_valid;
   logic                    handshake;
   logic                    last_beat;

   assign rd_valid  = en_sr_q[BRAM_LATENCY-1];
   assign handshake = valid_q & tile_ready_i;
   assign last_beat = (cnt_q == LAST_BEAT);

   always_comb begin
      en_sr_d    = en_sr_q << 1;
      en_sr_d[0] = bram_en_i;
   end

   // Assembly buffer including the beat arriving this cycle, so a completing
   // tile can go straight to the output register on the same edge.
   always_comb begin
      asm_d = asm_q;
      if (state_q == S_COLLECT && rd_valid)
         asm_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = bram_rdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_COLLECT;
         en_sr_q    <= '0;
         cnt_q      <= '0;
         asm_q      <= '0;
         out_q      <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
         count_q    <= '0;
      end else if (flush_i) begin
         state_q    <= S_COLLECT;
         en_sr_q    <= '0;
         cnt_q      <= '0;
         asm_q      <= '0;
         out_q      <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         en_sr_q <= en_sr_d;
         asm_q   <= asm_d;
         if (handshake) begin
            count_q <= count_q + 16'd1;
            valid_q <= 1'b0;
         end
         case (state_q)
            S_COLLECT: begin
               if (rd_valid) begin
                  if (!last_beat) begin
                     cnt_q <= cnt_q + CW'(1);
                  end else if (!valid_q || handshake) begin
                     out_q   <= asm_d;
                     valid_q <= 1'b1;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               // Beats landing here have nowhere to go and are dropped.
               if (rd_valid)
                  overflow_q <= 1'b1;
               if (handshake) begin
                  out_q   <= asm_q;
                  valid_q <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= S_COLLECT;
               end
            end
            default: state_q <= S_COLLECT;
         endcase
      end
   end

   assign tile_valid_o      = valid_q;
   assign tile_data_o       = out_q;
   assign fetch_ok_o        = (state_q == S_COLLECT) && (cnt_q == '0) && (en_sr_q == '0);
   assign overflow_o        = overflow_q;
   assign tiles_delivered_o = count_q;

endmodule

// File: tb/tb_tile_read_assembler.sv
// Directed bench for tile_read_assembler: default 2-beat instance plus a
// 1-beat, 8-bit instance used for the single-beat and counter-wrap cases.
module tb_tile_read_assembler;

   localparam int DW = 256;
   localparam int TW = 512;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            en, flush, ready;
   logic [DW-1:0]   rdata;
   logic            valid;
   logic [TW-1:0]   data;
   logic            fok, ovf;
   logic [15:0]     cnt;

   logic            en1, flush1, ready1;
   logic [7:0]      rdata1;
   logic            valid1;
   logic [7:0]      data1;
   logic            fok1, ovf1;
   logic [15:0]     cnt1;

   int errors = 0;
   int checks = 0;

   localparam logic [DW-1:0] WA = 256'hAAAA_0000_0000_0001;
   localparam logic [DW-1:0] WB = 256'hBBBB_0000_0000_0002;
   localparam logic [DW-1:0] P0 = 256'h5050_0000_0000_0010;
   localparam logic [DW-1:0] P1 = 256'h5151_0000_0000_0011;
   localparam logic [DW-1:0] Q0 = 256'h6060_0000_0000_0020;
   localparam logic [DW-1:0] Q1 = 256'h6161_0000_0000_0021;
   localparam logic [DW-1:0] RX = 256'hDEAD_BEEF;
   localparam logic [DW-1:0] WC = 256'hCCCC_0000_0000_0003;
   localparam logic [DW-1:0] WD = 256'hDDDD_0000_0000_0004;
   localparam logic [DW-1:0] E0 = 256'hE0E0;
   localparam logic [DW-1:0] E1 = 256'hE1E1;
   localparam logic [DW-1:0] F0 = 256'hF0F0;
   localparam logic [DW-1:0] F1 = 256'hF1F1;
   localparam logic [DW-1:0] G0 = 256'h9090;
   localparam logic [DW-1:0] G1 = 256'h9191;
   localparam logic [DW-1:0] H0 = 256'h7070;
   localparam logic [DW-1:0] H1 = 256'h7171;

   always #5 clk = ~clk;

   tile_read_assembler u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .bram_en_i         (en),
      .bram_rdata_i      (rdata),
      .flush_i           (flush),
      .tile_ready_i      (ready),
      .tile_valid_o      (valid),
      .tile_data_o       (data),
      .fetch_ok_o        (fok),
      .overflow_o        (ovf),
      .tiles_delivered_o (cnt)
   );

   tile_read_assembler #(.DATA_WIDTH(8), .NUM_FETCHES_PER_TILE(1), .BRAM_LATENCY(1)) u_one (
      .clk               (clk),
      .rst_n             (rst_n),
      .bram_en_i         (en1),
      .bram_rdata_i      (rdata1),
      .flush_i           (flush1),
      .tile_ready_i      (ready1),
      .tile_valid_o      (valid1),
      .tile_data_o       (data1),
      .fetch_ok_o        (fok1),
      .overflow_o        (ovf1),
      .tiles_delivered_o (cnt1)
   );

   // Drive one cycle of upstream inputs, then land 1 time unit after the edge.
   task automatic cyc(input logic e, input logic [DW-1:0] d);
      en    = e;
      rdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; en = 0; flush = 0; ready = 0; rdata = '0;
      en1 = 0; flush1 = 0; ready1 = 1; rdata1 = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
      checks++; if (data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", data); end
      checks++; if (fok !== 1'b1) begin errors++; $display("FAIL reset_fetch_ok got %b exp 1", fok); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", ovf); end
      checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic;
      ready = 1'b1;
      cyc(1, '0);
      cyc(1, WA);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", valid); end
      checks++; if (fok !== 1'b0) begin errors++; $display("FAIL basic_fetch_ok_busy got %b exp 0", fok); end
      cyc(0, WB);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", valid); end
      checks++; if (data !== {WB, WA}) begin errors++; $display("FAIL basic_data got %h exp %h", data, {WB, WA}); end
      checks++; if (fok !== 1'b1) begin errors++; $display("FAIL basic_fetch_ok got %b exp 1", fok); end
      cyc(0, '0);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b exp 0", valid); end
      checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", cnt); end
   endtask

   task automatic test_backpressure;
      ready = 1'b0;
      cyc(1, '0);
      cyc(1, P0);
      cyc(1, P1);
      cyc(1, Q0);
      cyc(0, Q1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", valid); end
      checks++; if (data !== {P1, P0}) begin errors++; $display("FAIL bp_data1 got %h exp %h", data, {P1, P0}); end
      checks++; if (fok !== 1'b0) begin errors++; $display("FAIL bp_fetch_ok got %b exp 0", fok); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_overflow_early got %b exp 0", ovf); end
      cyc(1, '0);
      cyc(0, RX);
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b exp 1", ovf); end
      checks++; if (data !== {P1, P0}) begin errors++; $display("FAIL bp_data_kept got %h exp %h", data, {P1, P0}); end
      ready = 1'b1;
      cyc(0, '0);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_valid2 got %b exp 1", valid); end
      checks++; if (data !== {Q1, Q0}) begin errors++; $display("FAIL bp_data2 got %h exp %h", data, {Q1, Q0}); end
      checks++; if (cnt !== 16'd2) begin errors++; $display("FAIL bp_count1 got %0d exp 2", cnt); end
      cyc(0, '0);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_valid_end got %b exp 0", valid); end
      checks++; if (cnt !== 16'd3) begin errors++; $display("FAIL bp_count2 got %0d exp 3", cnt); end
      checks++; if (fok !== 1'b1) begin errors++; $display("FAIL bp_fetch_ok_end got %b exp 1", fok); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky got %b exp 1", ovf); end
   endtask

   task automatic test_flush;
      cyc(1, '0);
      cyc(0, RX);
      checks++; if (fok !== 1'b0) begin errors++; $display("FAIL flush_partial_fetch_ok got %b exp 0", fok); end
      flush = 1'b1;
      cyc(0, '0);
      flush = 1'b0;
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL flush_overflow got %b exp 0", ovf); end
      checks++; if (fok !== 1'b1) begin errors++; $display("FAIL flush_fetch_ok got %b exp 1", fok); end
      checks++; if (cnt !== 16'd3) begin errors++; $display("FAIL flush_count got %0d exp 3", cnt); end
      cyc(1, '0);
      cyc(1, WC);
      cyc(0, WD);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL flush_valid got %b exp 1", valid); end
      checks++; if (data !== {WD, WC}) begin errors++; $display("FAIL flush_data got %h exp %h", data, {WD, WC}); end
      cyc(0, '0);
      checks++; if (cnt !== 16'd4) begin errors++; $display("FAIL flush_count2 got %0d exp 4", cnt); end
   endtask

   task automatic test_back_to_back;
      ready = 1'b0;
      cyc(1, '0);
      cyc(1, E0);
      cyc(0, E1);
      cyc(1, '0);
      cyc(1, F0);
      checks++; if (data !== {E1, E0}) begin errors++; $display("FAIL b2b_data1 got %h exp %h", data, {E1, E0}); end
      ready = 1'b1;
      cyc(0, F1);
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble got %b exp 1", valid); end
      checks++; if (data !== {F1, F0}) begin errors++; $display("FAIL b2b_data2 got %h exp %h", data, {F1, F0}); end
      checks++; if (cnt !== 16'd5) begin errors++; $display("FAIL b2b_count1 got %0d exp 5", cnt); end
      cyc(0, '0);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_end got %b exp 0", valid); end
      checks++; if (cnt !== 16'd6) begin errors++; $display("FAIL b2b_count2 got %0d exp 6", cnt); end
   endtask

   task automatic test_reset_mid_tile;
      cyc(1, '0);
      cyc(1, G0);
      rst_n = 1'b0;
      #2;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", valid); end
      checks++; if (data !== '0) begin errors++; $display("FAIL rst_mid_data got %h exp 0", data); end
      checks++; if (fok !== 1'b1) begin errors++; $display("FAIL rst_mid_fetch_ok got %b exp 1", fok); end
      checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_count got %0d exp 0", cnt); end
      rst_n = 1'b1;
      cyc(0, G1);
      checks++; if (fok !== 1'b1) begin errors++; $display("FAIL rst_mid_stale got %b exp 1", fok); end
      cyc(1, '0);
      cyc(1, H0);
      cyc(0, H1);
      checks++; if (data !== {H1, H0}) begin errors++; $display("FAIL rst_mid_next_tile got %h exp %h", data, {H1, H0}); end
      cyc(0, '0);
      checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL rst_mid_count2 got %0d exp 1", cnt); end
   endtask

   task automatic test_single_beat_wrap;
      en1 = 1'b1;
      @(posedge clk); #1;
      en1 = 1'b0; rdata1 = 8'h5A;
      @(posedge clk); #1;
      checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL one_valid got %b exp 1", valid1); end
      checks++; if (data1 !== 8'h5A) begin errors++; $display("FAIL one_data got %h exp 5a", data1); end
      @(posedge clk); #1;
      checks++; if (cnt1 !== 16'd1) begin errors++; $display("FAIL one_count got %0d exp 1", cnt1); end
      en1 = 1'b1;
      for (int i = 0; i < 65534; i++) begin
         rdata1 = 8'(i);
         @(posedge clk); #1;
      end
      en1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (cnt1 !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h exp ffff", cnt1); end
      en1 = 1'b1;
      @(posedge clk); #1;
      en1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (cnt1 !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", cnt1); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_flush;
      test_back_to_back;
      test_reset_mid_tile;
      test_single_beat_wrap;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
